lv_wdg_timer: RTL and testbench
===============================

// Module: lv_wdg_timer
// PURPOSE
//  Low-voltage-side watchdog. Enabled by the control FSM's o_wdg_scan_en; counts prescaled ticks between SPI refreshes.
//  Raises the sticky timeout flag that the control FSM consumes as i_reg_wdg_tmo_err (drives FAULT/CFG decisions).
//  Sits between the SPI register bank (refresh/config/clear) and lv_fsm_ctrl.
// PARAMETERS
//  WDG_TMO_W     8   width of timeout count and timeout config (units: prescaled ticks)
//  PRESCL_DIV    64  i_clk cycles per tick; legal range >=2
//  END_OF_LIST   1   list terminator, unused
// PORTS
//  i_clk               in   1          system clock
//  i_rst_n             in   1          asynchronous active-low reset
//  i_wdg_scan_en       in   1          watchdog enable from control FSM (o_wdg_scan_en)
//  i_wdg_refresh       in   1          1-cycle SPI refresh pulse
//  i_reg_wdg_tmo_cfg   in   WDG_TMO_W  timeout threshold in ticks; 0 = timeout disabled
//  i_reg_wdg_tmo_clr   in   1          1-cycle clear pulse for sticky error
//  o_reg_wdg_tmo_err   out  1          sticky timeout error -> lv_fsm_ctrl.i_reg_wdg_tmo_err
//  o_wdg_cnt           out  WDG_TMO_W  current tick count (status readback)
//  o_wdg_st            out  2          current FSM state (status readback)
// BEHAVIOUR
//  Reset: state IDLE, prescaler 0, o_wdg_cnt 0, o_reg_wdg_tmo_err 0, o_wdg_st 0.
//  States: IDLE=0, RUN=1, TMO=2; encoding 3 is illegal -> IDLE next cycle.
//  IDLE: prescaler/cnt held at 0; i_wdg_scan_en=1 -> RUN next cycle.
//  RUN: prescaler counts 0..PRESCL_DIV-1; a tick fires on the wrap cycle; cnt increments per tick, saturating at all-ones.
//   Refresh: prescaler and cnt cleared on the next edge.
//   Tick with cfg!=0 and cnt==cfg-1: go to TMO; err=1 on that same edge, i.e. cfg*PRESCL_DIV cycles after a refresh.
//   Refresh and the expiring tick in the same cycle: refresh wins, no error.
//   i_wdg_scan_en=0: go to IDLE, cnt=0; takes priority over a tick in the same cycle.
//   cfg changed mid-count: compared live. If cnt>=cfg-1 at the next tick, timeout fires.
//  TMO: err held 1; cnt frozen; refreshes ignored; i_wdg_scan_en ignored, so err stays sticky while the FSM is in FAULT/CFG.
//   Clear: err=0 next edge, cnt=0; next state RUN if i_wdg_scan_en=1, else IDLE.
//   Clear while not in TMO: no effect.
//  Async reset mid-count: all state returns to reset values immediately; no error is generated.
// CONFIGURATION
//  LV_WDG_WINDOW_EN defined:
//   Adds input i_reg_wdg_win_cfg [WDG_TMO_W] and output o_reg_wdg_early_err (sticky, reset 0).
//   A refresh in RUN with cnt < win_cfg is an early refresh: go to TMO and set early_err and tmo_err on the next edge.
//   i_reg_wdg_tmo_clr clears both flags. win_cfg=0 disables window checking.
//  LV_WDG_WINDOW_EN undefined: these ports do not exist; every refresh in RUN is accepted.
// STRUCTURE
//  Shared package/param include (lv_param.vh):
//   WDG_TMO_W, WDG_PRESCL_DIV defaults;
//   WDG_ST_W=2 and the state localparams (IDLE/RUN/TMO).
//  Sub-module lv_wdg_prescl: prescaler counter with sync clear.
//   Inputs: en, clr. Output: 1-cycle tick at PRESCL_DIV-1.
//  Top holds the FSM, tick counter, compare logic and sticky flags.
// TESTING
//  1 PRESCL_DIV=4, cfg=3, scan_en=1, no refresh -> err rises exactly 12 cycles after RUN entry; cnt frozen at 2.
//  2 Refresh every 10 cycles, cfg=3, for 200 cycles -> err stays 0; cnt never exceeds 2.
//  3 Refresh in the same cycle as the expiring tick -> no err; cnt=0 next cycle.
//  4 In TMO: drop scan_en, then pulse refresh -> err stays 1.
//    Then pulse clr with scan_en=0 -> err=0, state IDLE, cnt=0.
//  5 cfg=0, 2000 cycles, no refresh -> err=0 and cnt saturates at 255.
//    Assert i_rst_n low mid-count -> all outputs return to 0 asynchronously.
//  6 (LV_WDG_WINDOW_EN) win_cfg=2, refresh at cnt=1 -> early_err=1 and tmo_err=1.
//    Refresh at cnt=2 instead -> accepted, no error.

Source files
------------

// File: rtl/lv_wdg_timer_pkg.sv
// Shared widths, defaults and state encoding for the low-voltage watchdog.
package lv_wdg_timer_pkg;

  localparam int unsigned LV_WDG_TMO_W      = 8;
  localparam int unsigned LV_WDG_PRESCL_DIV = 64;
  localparam int unsigned WDG_ST_W          = 2;

  // Encoding 3 is illegal and recovers to IDLE.
  typedef enum logic [WDG_ST_W-1:0] {
    WDG_IDLE = 2'd0,
    WDG_RUN  = 2'd1,
    WDG_TMO  = 2'd2
  } wdg_st_e;

endpackage

// File: rtl/lv_wdg_prescl.sv
// Watchdog prescaler: counts 0..PRESCL_DIV-1 while enabled and emits a one-cycle tick on the wrap cycle.
module lv_wdg_prescl
  import lv_wdg_timer_pkg::*;
#(
  parameter int unsigned PRESCL_DIV = LV_WDG_PRESCL_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned PW = (PRESCL_DIV > 2) ? $clog2(PRESCL_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCL_DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick_c = en && (pcnt == P_LAST);

  // Held at zero while disabled; clear has priority over counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pcnt <= '0;
    end else if (clr || !en) begin
      pcnt <= '0;
    end else if (pcnt == P_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/lv_wdg_timer.sv
// Low-voltage watchdog: FSM, tick counter, timeout compare and sticky error flag.
// Optional early-refresh window checking is enabled by defining LV_WDG_WINDOW_EN.
module lv_wdg_timer
  import lv_wdg_timer_pkg::*;
#(
  parameter int unsigned WDG_TMO_W  = LV_WDG_TMO_W,
  parameter int unsigned PRESCL_DIV = LV_WDG_PRESCL_DIV
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wdg_scan_en,
  input  logic                 i_wdg_refresh,
  input  logic [WDG_TMO_W-1:0] i_reg_wdg_tmo_cfg,
  input  logic                 i_reg_wdg_tmo_clr,
`ifdef LV_WDG_WINDOW_EN
  input  logic [WDG_TMO_W-1:0] i_reg_wdg_win_cfg,
  output logic                 o_reg_wdg_early_err,
`endif
  output logic                 o_reg_wdg_tmo_err,
  output logic [WDG_TMO_W-1:0] o_wdg_cnt,
  output logic [WDG_ST_W-1:0]  o_wdg_st
);

  localparam int unsigned CW = WDG_TMO_W + 1;

  wdg_st_e              state;
  logic [WDG_TMO_W-1:0] cnt;
  logic                 tmo_err;
  logic                 tick_c;
  logic                 expire_c;

  lv_wdg_prescl #(
    .PRESCL_DIV (PRESCL_DIV)
  ) u_prescl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en      (state == WDG_RUN),
    .clr     (i_wdg_refresh || !i_wdg_scan_en),
    .tick_c  (tick_c)
  );

  // Live compare so a lowered threshold takes effect at the next tick.
  assign expire_c = (i_reg_wdg_tmo_cfg != '0) &&
                    ((CW'(cnt) + CW'(1)) >= CW'(i_reg_wdg_tmo_cfg));

`ifdef LV_WDG_WINDOW_EN
  logic early_err;
  logic early_c;

  assign early_c             = (i_reg_wdg_win_cfg != '0) && (cnt < i_reg_wdg_win_cfg);
  assign o_reg_wdg_early_err = early_err;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= WDG_IDLE;
      cnt       <= '0;
      tmo_err   <= 1'b0;
`ifdef LV_WDG_WINDOW_EN
      early_err <= 1'b0;
`endif
    end else begin
      case (state)
        WDG_IDLE: begin
          cnt <= '0;
          if (i_wdg_scan_en) state <= WDG_RUN;
        end
        WDG_RUN: begin
          if (!i_wdg_scan_en) begin
            state <= WDG_IDLE;
            cnt   <= '0;
          end else if (i_wdg_refresh) begin
`ifdef LV_WDG_WINDOW_EN
            if (early_c) begin
              state     <= WDG_TMO;
              tmo_err   <= 1'b1;
              early_err <= 1'b1;
            end else begin
              cnt <= '0;
            end
`else
            cnt <= '0;
`endif
          end else if (tick_c) begin
            if (expire_c) begin
              state   <= WDG_TMO;
              tmo_err <= 1'b1;
            end else if (cnt != '1) begin
              cnt <= cnt + WDG_TMO_W'(1);
            end
          end
        end
        // Sticky until cleared; scan_en and refresh are ignored here.
        WDG_TMO: begin
          if (i_reg_wdg_tmo_clr) begin
            tmo_err   <= 1'b0;
`ifdef LV_WDG_WINDOW_EN
            early_err <= 1'b0;
`endif
            cnt       <= '0;
            state     <= i_wdg_scan_en ? WDG_RUN : WDG_IDLE;
          end
        end
        default: begin
          state <= WDG_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_reg_wdg_tmo_err = tmo_err;
  assign o_wdg_cnt         = cnt;
  assign o_wdg_st          = state;

endmodule

// File: tb/tb_lv_wdg_timer.sv
// Directed self-checking bench for lv_wdg_timer with a 4-cycle prescaler.
module tb_lv_wdg_timer;

  localparam int unsigned W   = 8;
  localparam int unsigned DIV = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         scan_en;
  logic         refresh;
  logic [W-1:0] tmo_cfg;
  logic         tmo_clr;
  logic         tmo_err;
  logic [W-1:0] wdg_cnt;
  logic [1:0]   wdg_st;
`ifdef LV_WDG_WINDOW_EN
  logic [W-1:0] win_cfg;
  logic         early_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lv_wdg_timer #(
    .WDG_TMO_W  (W),
    .PRESCL_DIV (DIV)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_wdg_scan_en       (scan_en),
    .i_wdg_refresh       (refresh),
    .i_reg_wdg_tmo_cfg   (tmo_cfg),
    .i_reg_wdg_tmo_clr   (tmo_clr),
`ifdef LV_WDG_WINDOW_EN
    .i_reg_wdg_win_cfg   (win_cfg),
    .o_reg_wdg_early_err (early_err),
`endif
    .o_reg_wdg_tmo_err   (tmo_err),
    .o_wdg_cnt           (wdg_cnt),
    .o_wdg_st            (wdg_st)
  );

  // Counts cycles until err rises, bounded; leaves k at the count.
  task automatic wait_err(output int k);
    k = 0;
    while (tmo_err !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    scan_en = 1'b0;
    refresh = 1'b0;
    tmo_cfg = '0;
    tmo_clr = 1'b0;
`ifdef LV_WDG_WINDOW_EN
    win_cfg = '0;
`endif
    #12;
    n_tests++;
    if ({tmo_err, wdg_cnt, wdg_st} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: err=%b cnt=%0d st=%0d, want all 0", tmo_err, wdg_cnt, wdg_st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wdg_st !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_hold: st=%0d want 0", wdg_st);
    end
  endtask

  task automatic test_timeout();
    int k;
    tmo_cfg = 8'd3;
    scan_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wdg_st !== 2'd1 || tmo_err !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: st=%0d err=%b want st=1 err=0", wdg_st, tmo_err);
    end
    wait_err(k);
    n_tests++;
    if (k != 12) begin
      n_fail++;
      $display("FAIL tmo_latency: %0d cycles want 12", k);
    end
    n_tests++;
    if (wdg_cnt !== 8'd2 || wdg_st !== 2'd2) begin
      n_fail++;
      $display("FAIL tmo_state: cnt=%0d st=%0d want cnt=2 st=2", wdg_cnt, wdg_st);
    end
  endtask

  task automatic test_sticky_clear();
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    @(negedge clk);
    n_tests++;
    if (tmo_err !== 1'b1 || wdg_st !== 2'd2 || wdg_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sticky: err=%b st=%0d cnt=%0d want 1/2/2", tmo_err, wdg_st, wdg_cnt);
    end
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    n_tests++;
    if (tmo_err !== 1'b0 || wdg_st !== 2'd0 || wdg_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_idle: err=%b st=%0d cnt=%0d want 0/0/0", tmo_err, wdg_st, wdg_cnt);
    end
  endtask

  task automatic test_periodic_refresh();
    int max_cnt = 0;
    int saw_err = 0;
    tmo_cfg = 8'd3;
    scan_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      refresh = (i % 10 == 9);
      @(negedge clk);
      if (int'(wdg_cnt) > max_cnt) max_cnt = int'(wdg_cnt);
      if (tmo_err === 1'b1) saw_err = 1;
    end
    refresh = 1'b0;
    n_tests++;
    if (saw_err != 0) begin
      n_fail++;
      $display("FAIL periodic_err: err seen=%0d want 0", saw_err);
    end
    n_tests++;
    if (max_cnt != 2) begin
      n_fail++;
      $display("FAIL periodic_max: max cnt=%0d want 2", max_cnt);
    end
  endtask

  task automatic test_refresh_race();
    int k;
    scan_en = 1'b0;
    @(negedge clk);
    scan_en = 1'b1;
    @(negedge clk);
    repeat (11) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    n_tests++;
    if (tmo_err !== 1'b0 || wdg_cnt !== 8'd0 || wdg_st !== 2'd1) begin
      n_fail++;
      $display("FAIL race: err=%b cnt=%0d st=%0d want 0/0/1", tmo_err, wdg_cnt, wdg_st);
    end
    wait_err(k);
    n_tests++;
    if (k != 12) begin
      n_fail++;
      $display("FAIL race_restart: %0d cycles want 12", k);
    end
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    n_tests++;
    if (tmo_err !== 1'b0 || wdg_st !== 2'd1 || wdg_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_run: err=%b st=%0d cnt=%0d want 0/1/0", tmo_err, wdg_st, wdg_cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    tmo_cfg = 8'd0;
    repeat (2000) @(negedge clk);
    n_tests++;
    if (tmo_err !== 1'b0 || wdg_cnt !== 8'd255 || wdg_st !== 2'd1) begin
      n_fail++;
      $display("FAIL saturate: err=%b cnt=%0d st=%0d want 0/255/1", tmo_err, wdg_cnt, wdg_st);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tmo_err, wdg_cnt, wdg_st} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: err=%b cnt=%0d st=%0d want all 0", tmo_err, wdg_cnt, wdg_st);
    end
    scan_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef LV_WDG_WINDOW_EN
  task automatic test_window();
    tmo_cfg = 8'd10;
    win_cfg = 8'd2;
    scan_en = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    n_tests++;
    if (early_err !== 1'b1 || tmo_err !== 1'b1 || wdg_st !== 2'd2) begin
      n_fail++;
      $display("FAIL early: early=%b err=%b st=%0d want 1/1/2", early_err, tmo_err, wdg_st);
    end
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    repeat (9) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    n_tests++;
    if (early_err !== 1'b0 || tmo_err !== 1'b0 || wdg_cnt !== 8'd0 || wdg_st !== 2'd1) begin
      n_fail++;
      $display("FAIL window_ok: early=%b err=%b cnt=%0d st=%0d want 0/0/0/1",
               early_err, tmo_err, wdg_cnt, wdg_st);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_sticky_clear();
    test_periodic_refresh();
    test_refresh_race();
    test_saturate_and_reset();
`ifdef LV_WDG_WINDOW_EN
    test_window();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
